// File: rtl/apb_node_timeout.sv
// ---------------------------------------------------------------------------
// apb_node_timeout
//
// APB fan-out stage placed behind the AXI-to-APB bridge. It takes the
// bridge's held request, decodes the address against a runtime map, runs a
// SETUP/ACCESS sequence on the selected peripheral and returns a single
// registered completion pulse. Unmapped addresses and peripherals that stall
// in ACCESS for TIMEOUT_CYCLES cycles complete with an error instead of
// hanging the bus.
//
// Ports
//   ACLK, ARESET            clock, synchronous active-high reset
//   PENABLE_i, PWRITE_i,    upstream request (held until PREADY_o),
//   PADDR_i, PWDATA_i       direction, address, write data
//   PRDATA_o, PREADY_o,     upstream response: read data, one-cycle
//   PSLVERR_o               completion pulse, error flag
//   START_ADDR_i,           per-slave inclusive address window, slice k
//   END_ADDR_i              belongs to slave k
//   PSEL_o, PENABLE_o,      downstream APB master: one-hot select, access
//   PWRITE_o, PADDR_o,      phase, registered direction/address/data
//   PWDATA_o
//   PRDATA_i, PREADY_i,     downstream responses, slice/bit k = slave k
//   PSLVERR_i
//   timeout_o               one-cycle pulse when an access is aborted
// ---------------------------------------------------------------------------
module apb_node_timeout #(
    parameter int NB_SLAVES      = 4,
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                 ACLK,
    input  logic                                 ARESET,

    input  logic                                 PENABLE_i,
    input  logic                                 PWRITE_i,
    input  logic [APB_ADDR_WIDTH-1:0]            PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0]            PWDATA_i,
    output logic [APB_DATA_WIDTH-1:0]            PRDATA_o,
    output logic                                 PREADY_o,
    output logic                                 PSLVERR_o,

    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0]  START_ADDR_i,
    input  logic [NB_SLAVES*APB_ADDR_WIDTH-1:0]  END_ADDR_i,

    output logic [NB_SLAVES-1:0]                 PSEL_o,
    output logic                                 PENABLE_o,
    output logic                                 PWRITE_o,
    output logic [APB_ADDR_WIDTH-1:0]            PADDR_o,
    output logic [APB_DATA_WIDTH-1:0]            PWDATA_o,
    input  logic [NB_SLAVES*APB_DATA_WIDTH-1:0]  PRDATA_i,
    input  logic [NB_SLAVES-1:0]                 PREADY_i,
    input  logic [NB_SLAVES-1:0]                 PSLVERR_i,

    output logic                                 timeout_o
);

    localparam int IDX_W   = (NB_SLAVES > 1) ? $clog2(NB_SLAVES) : 1;
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Last ACCESS cycle index allowed before the abort fires.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          sel_q, sel_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic [NB_SLAVES-1:0]      psel_d;
    logic                      penable_d;
    logic                      pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_d;
    logic [APB_DATA_WIDTH-1:0] prdata_d;
    logic                      pready_d;
    logic                      pslverr_d;
    logic                      timeout_d;

    // Address decode: lowest-indexed matching window wins. An inverted
    // window (start > end) can never satisfy both compares.
    logic                      hit;
    logic [IDX_W-1:0]          hit_idx;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (!hit &&
                PADDR_i >= START_ADDR_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH] &&
                PADDR_i <= END_ADDR_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(k);
            end
        end
    end

    // Response of the currently selected slave; all others are ignored.
    logic [APB_DATA_WIDTH-1:0] sel_rdata;
    logic                      sel_ready;
    logic                      sel_err;
    logic [NB_SLAVES-1:0]      sel_onehot;

    always_comb begin
        sel_rdata  = '0;
        sel_ready  = 1'b0;
        sel_err    = 1'b0;
        sel_onehot = '0;
        for (int k = 0; k < NB_SLAVES; k++) begin
            if (sel_q == IDX_W'(k)) begin
                sel_rdata     = PRDATA_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                sel_ready     = PREADY_i[k];
                sel_err       = PSLVERR_i[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and next-output logic. Every output is registered, so the
    // values computed here are the ones visible in the following state.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        pwrite_d  = PWRITE_o;
        paddr_d   = PADDR_o;
        pwdata_d  = PWDATA_o;
        psel_d    = '0;
        penable_d = 1'b0;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        timeout_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (PENABLE_i) begin
                    pwrite_d = PWRITE_i;
                    paddr_d  = PADDR_i;
                    pwdata_d = PWDATA_i;
                    if (hit) begin
                        sel_d           = hit_idx;
                        psel_d[hit_idx] = 1'b1;
                        state_d         = S_SETUP;
                    end else begin
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        state_d   = S_RESP;
                    end
                end
            end

            S_SETUP: begin
                psel_d    = sel_onehot;
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (sel_ready) begin
                    pready_d  = 1'b1;
                    pslverr_d = sel_err;
                    prdata_d  = PWRITE_o ? '0 : sel_rdata;
                    state_d   = S_RESP;
                end else if (TIMEOUT_EN && cnt_q == CNT_LAST) begin
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    timeout_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    // With the timeout disabled the counter is held so it
                    // cannot wrap during an unbounded wait.
                    if (TIMEOUT_EN) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    psel_d    = sel_onehot;
                    penable_d = 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (ARESET) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            PSEL_o    <= '0;
            PENABLE_o <= 1'b0;
            PWRITE_o  <= 1'b0;
            PADDR_o   <= '0;
            PWDATA_o  <= '0;
            PRDATA_o  <= '0;
            PREADY_o  <= 1'b0;
            PSLVERR_o <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            PSEL_o    <= psel_d;
            PENABLE_o <= penable_d;
            PWRITE_o  <= pwrite_d;
            PADDR_o   <= paddr_d;
            PWDATA_o  <= pwdata_d;
            PRDATA_o  <= prdata_d;
            PREADY_o  <= pready_d;
            PSLVERR_o <= pslverr_d;
            timeout_o <= timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_node_timeout.sv
// ---------------------------------------------------------------------------
// tb_apb_node_timeout
//
// Self-checking bench for apb_node_timeout (4 slaves, 32-bit buses,
// TIMEOUT_CYCLES = 8). Behavioural slave models answer after a programmable
// number of ACCESS wait cycles; non-selected slaves drive random noise.
// ---------------------------------------------------------------------------
module tb_apb_node_timeout;

    localparam int NS     = 4;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TO     = 8;
    localparam int BUDGET = 40;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic             PENABLE_i;
    logic             PWRITE_i;
    logic [AW-1:0]    PADDR_i;
    logic [DW-1:0]    PWDATA_i;
    logic [DW-1:0]    PRDATA_o;
    logic             PREADY_o;
    logic             PSLVERR_o;
    logic [NS*AW-1:0] START_ADDR_i;
    logic [NS*AW-1:0] END_ADDR_i;
    logic [NS-1:0]    PSEL_o;
    logic             PENABLE_o;
    logic             PWRITE_o;
    logic [AW-1:0]    PADDR_o;
    logic [DW-1:0]    PWDATA_o;
    logic [NS*DW-1:0] PRDATA_i;
    logic [NS-1:0]    PREADY_i;
    logic [NS-1:0]    PSLVERR_i;
    logic             timeout_o;

    apb_node_timeout #(
        .NB_SLAVES      (NS),
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .PENABLE_i    (PENABLE_i),
        .PWRITE_i     (PWRITE_i),
        .PADDR_i      (PADDR_i),
        .PWDATA_i     (PWDATA_i),
        .PRDATA_o     (PRDATA_o),
        .PREADY_o     (PREADY_o),
        .PSLVERR_o    (PSLVERR_o),
        .START_ADDR_i (START_ADDR_i),
        .END_ADDR_i   (END_ADDR_i),
        .PSEL_o       (PSEL_o),
        .PENABLE_o    (PENABLE_o),
        .PWRITE_o     (PWRITE_o),
        .PADDR_o      (PADDR_o),
        .PWDATA_o     (PWDATA_o),
        .PRDATA_i     (PRDATA_i),
        .PREADY_i     (PREADY_i),
        .PSLVERR_i    (PSLVERR_i),
        .timeout_o    (timeout_o)
    );

    always #5 ACLK = ~ACLK;

    // Address map and slave behaviour, set by the stimulus.
    logic [AW-1:0] start_a   [NS];
    logic [AW-1:0] end_a     [NS];
    logic [7:0]    slv_wait  [NS];
    logic [DW-1:0] slv_rdata [NS];
    logic          slv_err   [NS];
    logic [NS-1:0] noise_rdy;
    logic [NS-1:0] noise_err;
    logic [DW-1:0] noise_data [NS];

    // Number of consecutive ACCESS cycles seen so far on the downstream bus.
    logic [7:0] acc_cnt;
    always_ff @(posedge ACLK) begin
        if (|PSEL_o && PENABLE_o) acc_cnt <= acc_cnt + 8'd1;
        else                      acc_cnt <= 8'd0;
    end

    for (genvar k = 0; k < NS; k++) begin : g_slv
        assign START_ADDR_i[k*AW +: AW] = start_a[k];
        assign END_ADDR_i[k*AW +: AW]   = end_a[k];
        assign PREADY_i[k]  = PSEL_o[k] ? (PENABLE_o && acc_cnt == slv_wait[k]) : noise_rdy[k];
        assign PSLVERR_i[k] = PSEL_o[k] ? slv_err[k] : noise_err[k];
        assign PRDATA_i[k*DW +: DW] = PSEL_o[k] ? slv_rdata[k] : noise_data[k];
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic randomize_noise();
        noise_rdy = NS'($urandom);
        noise_err = NS'($urandom);
        for (int k = 0; k < NS; k++) noise_data[k] = $urandom;
    endtask

    task automatic set_slaves(input logic [7:0] wt, input logic [DW-1:0] rd, input logic er);
        for (int k = 0; k < NS; k++) begin
            slv_wait[k]  = wt;
            slv_rdata[k] = rd;
            slv_err[k]   = er;
        end
    endtask

    task automatic set_table_map();
        start_a[0] = 32'h1A10_0000; end_a[0] = 32'h1A10_0FFF;
        start_a[1] = 32'h1A10_1000; end_a[1] = 32'h1A10_1FFF;
        start_a[2] = 32'h2000_0000; end_a[2] = 32'h2000_00FF;
        start_a[3] = 32'h3000_0100; end_a[3] = 32'h3000_0000;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " psel"},   64'(PSEL_o), 64'h0);
        check({tag, " ctl"},    64'({PENABLE_o, PWRITE_o, PREADY_o, PSLVERR_o, timeout_o}), 64'h0);
        check({tag, " paddr"},  64'(PADDR_o), 64'h0);
        check({tag, " pwdata"}, 64'(PWDATA_o), 64'h0);
        check({tag, " prdata"}, 64'(PRDATA_o), 64'h0);
    endtask

    // One upstream transaction, started so that the request is sampled at
    // the edge ending cycle 0; outputs are sampled on falling edges, so the
    // n-th sample is cycle n. proto_ok collects the per-cycle bus rules.
    task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output logic [NS-1:0] psel_seen,
                           output logic [DW-1:0] rd, output logic err, output logic to,
                           output logic proto_ok);
        lat = 0; psel_seen = '0; rd = '0; err = 1'b0; to = 1'b0; proto_ok = 1'b1;
        @(negedge ACLK);
        PENABLE_i = 1'b1; PWRITE_i = w; PADDR_i = a; PWDATA_i = d;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge ACLK);
            psel_seen |= PSEL_o;
            if (PREADY_o) begin
                lat = cyc; rd = PRDATA_o; err = PSLVERR_o; to = timeout_o;
                if (PSEL_o != '0 || PENABLE_o) proto_ok = 1'b0;
                break;
            end
            if (timeout_o || $countones(PSEL_o) != 1) proto_ok = 1'b0;
            if (PENABLE_o != (cyc >= 2)) proto_ok = 1'b0;
            if (PADDR_o != a || PWRITE_o != w || PWDATA_o != d) proto_ok = 1'b0;
            // The request stays asserted but its buses may change freely.
            PWRITE_i = 1'($urandom); PADDR_i = $urandom; PWDATA_i = $urandom;
            randomize_noise();
        end
        PENABLE_i = 1'b0;
        @(negedge ACLK);
        if (PREADY_o || PSEL_o != '0 || timeout_o) proto_ok = 1'b0;
    endtask

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [7:0]    wt;
        logic [DW-1:0] rdat;
        logic          serr;
        logic [NS-1:0] e_psel;
        int            e_lat;
        logic [DW-1:0] e_rd;
        logic          e_err;
        logic          e_to;
    } vec_t;

    vec_t vecs [12];

    int            lat;
    logic [NS-1:0] psel_seen;
    logic [DW-1:0] rd;
    logic          err, to, proto;

    task automatic check_txn(input string tag, input logic [NS-1:0] e_psel, input int e_lat,
                             input logic [DW-1:0] e_rd, input logic e_err, input logic e_to);
        check({tag, " lat"},     64'(lat), 64'(e_lat));
        check({tag, " psel"},    64'(psel_seen), 64'(e_psel));
        check({tag, " prdata"},  64'(rd), 64'(e_rd));
        check({tag, " pslverr"}, 64'(err), 64'(e_err));
        check({tag, " timeout"}, 64'(to), 64'(e_to));
        check({tag, " proto"},   64'(proto), 64'h1);
    endtask

    initial begin
        ARESET = 1'b1; PENABLE_i = 1'b0; PWRITE_i = 1'b0; PADDR_i = '0; PWDATA_i = '0;
        set_table_map();
        set_slaves(8'd0, 32'h0, 1'b0);
        randomize_noise();

        // Reset state.
        repeat (3) @(negedge ACLK);
        check_reset_outputs("reset");
        ARESET = 1'b0;

        // Directed table against the fixed map (slave3 window is inverted).
        vecs[0]  = '{1'b0, 32'h1A10_1004, 32'h0,         8'd0, 32'hCAFE_F00D, 1'b0, 4'b0010, 3,  32'hCAFE_F00D, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h1A10_0008, 32'h1234_5678, 8'd3, 32'hFFFF_FFFF, 1'b0, 4'b0001, 6,  32'h0,         1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,         8'd0, 32'h5555_5555, 1'b0, 4'b0000, 1,  32'h0,         1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h1A10_0000, 32'h0,         8'd1, 32'h1111_2222, 1'b0, 4'b0001, 4,  32'h1111_2222, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h1A10_1FFF, 32'h0,         8'd0, 32'hA5A5_0F0F, 1'b0, 4'b0010, 3,  32'hA5A5_0F0F, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h1A10_2000, 32'h0,         8'd0, 32'h1,         1'b0, 4'b0000, 1,  32'h0,         1'b1, 1'b0};
        vecs[6]  = '{1'b0, 32'h3000_0080, 32'h0,         8'd0, 32'h1,         1'b0, 4'b0000, 1,  32'h0,         1'b1, 1'b0};
        vecs[7]  = '{1'b0, 32'h2000_0010, 32'h0,         8'd7, 32'h0000_0077, 1'b0, 4'b0100, 10, 32'h0000_0077, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h2000_0010, 32'h0,         8'd8, 32'h0000_0077, 1'b0, 4'b0100, 10, 32'h0,         1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'h2000_00FF, 32'h0BAD_BEEF, 8'd0, 32'h9999_9999, 1'b1, 4'b0100, 3,  32'h0,         1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'h1A10_0FFC, 32'h0,         8'd2, 32'hDEAD_BEEF, 1'b1, 4'b0001, 5,  32'hDEAD_BEEF, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 32'h1A0F_FFFF, 32'h0,         8'd0, 32'h1,         1'b0, 4'b0000, 1,  32'h0,         1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            set_slaves(vecs[i].wt, vecs[i].rdat, vecs[i].serr);
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, lat, psel_seen, rd, err, to, proto);
            check_txn($sformatf("vec%0d", i), vecs[i].e_psel, vecs[i].e_lat,
                      vecs[i].e_rd, vecs[i].e_err, vecs[i].e_to);
        end

        // Overlapping windows: slave0 and slave2 both cover 0x100.
        start_a[0] = 32'h0000_0000; end_a[0] = 32'h0000_01FF;
        start_a[2] = 32'h0000_0100; end_a[2] = 32'h0000_02FF;
        set_slaves(8'd1, 32'h0000_ABCD, 1'b1);
        run_txn(1'b0, 32'h0000_0100, 32'h0, lat, psel_seen, rd, err, to, proto);
        check_txn("overlap", 4'b0001, 4, 32'h0000_ABCD, 1'b1, 1'b0);
        set_table_map();

        // A request held high past RESP restarts from IDLE: miss pulses on
        // cycles 1 and 3.
        begin
            logic [3:0] pat;
            pat = '0;
            @(negedge ACLK);
            PENABLE_i = 1'b1; PWRITE_i = 1'b0; PADDR_i = 32'h0;
            for (int c = 0; c < 4; c++) begin
                @(negedge ACLK);
                pat[c] = PREADY_o;
            end
            PENABLE_i = 1'b0;
            check("held_req pready", 64'(pat), 64'b0101);
            repeat (2) @(negedge ACLK);
        end

        // Reset asserted during ACCESS drops the transaction.
        begin
            logic any_ready;
            set_slaves(8'd100, 32'h1357_9BDF, 1'b0);
            @(negedge ACLK);
            PENABLE_i = 1'b1; PWRITE_i = 1'b1; PADDR_i = 32'h1A10_0010; PWDATA_i = 32'hA5A5_A5A5;
            repeat (3) @(negedge ACLK);
            check("rst_mid penable", 64'(PENABLE_o), 64'h1);
            ARESET = 1'b1; PENABLE_i = 1'b0;
            @(negedge ACLK);
            check_reset_outputs("rst_mid");
            ARESET = 1'b0;
            any_ready = 1'b0;
            for (int c = 0; c < 12; c++) begin
                @(negedge ACLK);
                any_ready |= PREADY_o | (|PSEL_o);
            end
            check("rst_mid quiet", 64'(any_ready), 64'h0);
            set_slaves(8'd0, 32'h2468_ACE0, 1'b0);
            run_txn(1'b0, 32'h1A10_0010, 32'h0, lat, psel_seen, rd, err, to, proto);
            check_txn("after_rst", 4'b0001, 3, 32'h2468_ACE0, 1'b0, 1'b0);
        end

        // Randomized transactions against a rule-level model of the node.
        for (int it = 0; it < 30; it++) begin
            logic          w;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            int            idx;
            int            e_lat;
            logic [NS-1:0] e_psel;
            logic [DW-1:0] e_rd;
            logic          e_err, e_to;

            for (int k = 0; k < NS; k++) begin
                start_a[k] = $urandom_range(1, 32'h3FF);
                if ($urandom_range(0, 7) == 0) end_a[k] = start_a[k] - 1;
                else                           end_a[k] = start_a[k] + $urandom_range(0, 32'h1FF);
                slv_wait[k]  = 8'($urandom_range(0, 10));
                slv_rdata[k] = $urandom;
                slv_err[k]   = 1'($urandom_range(0, 1));
            end
            w = 1'($urandom_range(0, 1));
            a = $urandom_range(0, 32'h5FF);
            d = $urandom;

            idx = -1;
            for (int k = NS - 1; k >= 0; k--)
                if (a >= start_a[k] && a <= end_a[k]) idx = k;

            e_psel = '0; e_rd = '0; e_to = 1'b0;
            if (idx < 0) begin
                e_lat = 1; e_err = 1'b1;
            end else begin
                e_psel[idx] = 1'b1;
                if (int'(slv_wait[idx]) < TO) begin
                    e_lat = 3 + int'(slv_wait[idx]);
                    e_err = slv_err[idx];
                    e_rd  = w ? '0 : slv_rdata[idx];
                end else begin
                    e_lat = TO + 2; e_err = 1'b1; e_to = 1'b1;
                end
            end

            run_txn(w, a, d, lat, psel_seen, rd, err, to, proto);
            check_txn($sformatf("rnd%0d", it), e_psel, e_lat, e_rd, e_err, e_to);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
